// File: rtl/tx_frame_arbiter_pkg.sv
// Shared types and default header bytes for the two-source UART frame arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HDR  = 2'd1,
    ARB_BODY = 2'd2
  } arb_state_t;

  localparam logic [7:0] HDR_ANGLE  = 8'hA5;
  localparam logic [7:0] HDR_STATUS = 8'h5A;

endpackage

// File: rtl/tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter merging two FWFT byte FIFOs into one FWFT stream,
// prefixing each frame with a per-source header byte.
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int         LEN0  = 24,
  parameter int         LEN1  = 4,
  parameter logic [7:0] HDR0  = HDR_ANGLE,
  parameter logic [7:0] HDR1  = HDR_STATUS,
  parameter int         CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s0_dout,
  input  logic             s0_empty,
  input  logic [CNT_W-1:0] s0_count,
  output logic             s0_re,
  input  logic [7:0]       s1_dout,
  input  logic             s1_empty,
  input  logic [CNT_W-1:0] s1_count,
  output logic             s1_re,
  output logic [7:0]       tx_din,
  output logic             tx_empty,
  input  logic             tx_re,
  output logic             busy,
  output logic             grant,
  output logic [15:0]      frames_sent
);

  localparam logic [CNT_W-1:0] LEN0_C  = CNT_W'(LEN0);
  localparam logic [CNT_W-1:0] LEN1_C  = CNT_W'(LEN1);
  localparam logic [7:0]       LAST0_C = 8'(LEN0 - 1);
  localparam logic [7:0]       LAST1_C = 8'(LEN1 - 1);

  arb_state_t  state_q, state_d;
  logic        rr_pri_q, rr_pri_d;
  logic        grant_q, grant_d;
  logic [7:0]  body_cnt_q, body_cnt_d;
  logic [15:0] frames_q, frames_d;

  // A source only competes once a whole body is buffered, so a body never stalls.
  logic elig0, elig1;
  assign elig0 = (s0_count >= LEN0_C);
  assign elig1 = (s1_count >= LEN1_C);

  logic       src_empty;
  logic [7:0] src_dout;
  logic [7:0] last_idx;
  assign src_empty = grant_q ? s1_empty : s0_empty;
  assign src_dout  = grant_q ? s1_dout  : s0_dout;
  assign last_idx  = grant_q ? LAST1_C  : LAST0_C;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_pri_q   <= 1'b0;
      grant_q    <= 1'b0;
      body_cnt_q <= 8'd0;
      frames_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      rr_pri_q   <= rr_pri_d;
      grant_q    <= grant_d;
      body_cnt_q <= body_cnt_d;
      frames_q   <= frames_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_pri_d   = rr_pri_q;
    grant_d    = grant_q;
    body_cnt_d = body_cnt_q;
    frames_d   = frames_q;
    tx_empty   = 1'b1;
    tx_din     = 8'h00;
    s0_re      = 1'b0;
    s1_re      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (elig0 || elig1) begin
          grant_d = (elig0 && elig1) ? rr_pri_q : elig1;
          state_d = ARB_HDR;
        end
      end

      ARB_HDR: begin
        tx_empty = 1'b0;
        tx_din   = grant_q ? HDR1 : HDR0;
        if (tx_re) begin
          state_d    = ARB_BODY;
          body_cnt_d = 8'd0;
        end
      end

      ARB_BODY: begin
        // An underflowing source just stalls the stream until its data returns.
        if (!src_empty) begin
          tx_empty = 1'b0;
          tx_din   = src_dout;
          s0_re    = tx_re & ~grant_q;
          s1_re    = tx_re &  grant_q;
          if (tx_re) begin
            body_cnt_d = body_cnt_q + 8'd1;
            if (body_cnt_q == last_idx) begin
              state_d  = ARB_IDLE;
              rr_pri_d = ~grant_q;
              frames_d = frames_q + 16'd1;
            end
          end
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  assign busy        = (state_q != ARB_IDLE);
  assign grant       = grant_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: FWFT source FIFOs modelled as queues, frame-level stream model.
module tb_tx_frame_arbiter;
  import tx_arb_pkg::*;

  localparam int LEN0  = 24;
  localparam int LEN1  = 4;
  localparam int CNT_W = 9;

  logic             clk;
  logic             rst;
  logic [7:0]       s0_dout, s1_dout;
  logic             s0_empty, s1_empty;
  logic [CNT_W-1:0] s0_count, s1_count;
  logic             s0_re, s1_re;
  logic [7:0]       tx_din;
  logic             tx_empty;
  logic             tx_re;
  logic             busy;
  logic             grant;
  logic [15:0]      frames_sent;

  tx_frame_arbiter #(
    .LEN0(LEN0), .LEN1(LEN1), .HDR0(8'hA5), .HDR1(8'h5A), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .s0_dout(s0_dout), .s0_empty(s0_empty), .s0_count(s0_count), .s0_re(s0_re),
    .s1_dout(s1_dout), .s1_empty(s1_empty), .s1_count(s1_count), .s1_re(s1_re),
    .tx_din(tx_din), .tx_empty(tx_empty), .tx_re(tx_re),
    .busy(busy), .grant(grant), .frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit         force_e0 = 1'b0;
  bit         spam_idle = 1'b0;
  int         tcyc = 0;
  int         n_re0 = 0;
  int         n_re1 = 0;
  bit         obs_empty, obs_re0, obs_re1;
  logic [7:0] obs_din;
  bit         obs_grant;

  bit         m_rr = 1'b0;
  logic [15:0] exp_fs = 16'd0;
  int         exp_r0 = 0;
  int         exp_r1 = 0;
  logic [7:0] seq = 8'd0;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
  endtask

  task automatic drive_src();
    s0_empty = (q0.size() == 0) || force_e0;
    s0_dout  = (q0.size() != 0) ? q0[0] : 8'h00;
    s0_count = CNT_W'(q0.size());
    s1_empty = (q1.size() == 0);
    s1_dout  = (q1.size() != 0) ? q1[0] : 8'h00;
    s1_count = CNT_W'(q1.size());
  endtask

  // One clock: drive, sample mid-cycle, take the edge, then apply the sources' pops.
  task automatic step(input bit re);
    drive_src();
    tx_re = re;
    #1;
    if (spam_idle && tx_empty) tx_re = tcyc[0];
    #1;
    obs_empty = tx_empty;
    obs_din   = tx_din;
    obs_re0   = s0_re;
    obs_re1   = s1_re;
    obs_grant = grant;
    if (tx_re && !tx_empty) got.push_back(tx_din);
    if (s0_re) begin
      n_re0++;
      chk("s0_re_qual", int'(tx_re && !tx_empty && !s1_re && tx_din == s0_dout && !s0_empty), 1);
    end
    if (s1_re) begin
      n_re1++;
      chk("s1_re_qual", int'(tx_re && !tx_empty && !s0_re && tx_din == s1_dout && !s1_empty), 1);
    end
    @(posedge clk);
    #1;
    if (obs_re0 && q0.size() != 0) void'(q0.pop_front());
    if (obs_re1 && q1.size() != 0) void'(q1.pop_front());
    tcyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    m_rr = 1'b0;
    exp_fs = 16'd0;
    drive_src();
    tx_re = 1'b1;
    #1;
    chk("rst_tx_empty", int'(tx_empty), 1);
    chk("rst_s0_re", int'(s0_re), 0);
    chk("rst_s1_re", int'(s1_re), 0);
    chk("rst_frames", int'(frames_sent), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant), 0);
    tx_re = 1'b0;
  endtask

  task automatic push0(input int n);
    for (int i = 0; i < n; i++) begin q0.push_back(seq); seq = seq + 8'd1; end
  endtask
  task automatic push1(input int n);
    for (int i = 0; i < n; i++) begin q1.push_back(seq); seq = seq + 8'd1; end
  endtask

  // Frame-level model: whole frames while a source holds >= LEN bytes, round-robin on ties.
  task automatic build_expected();
    logic [7:0] c0[$];
    logic [7:0] c1[$];
    bit e0, e1, g;
    c0 = q0;
    c1 = q1;
    got.delete();
    exp_q.delete();
    forever begin
      e0 = (c0.size() >= LEN0);
      e1 = (c1.size() >= LEN1);
      if (!e0 && !e1) break;
      g = (e0 && e1) ? m_rr : e1;
      if (!g) begin
        exp_q.push_back(8'hA5);
        for (int i = 0; i < LEN0; i++) exp_q.push_back(c0.pop_front());
      end else begin
        exp_q.push_back(8'h5A);
        for (int i = 0; i < LEN1; i++) exp_q.push_back(c1.pop_front());
      end
      m_rr = !g;
      exp_fs = exp_fs + 16'd1;
    end
    exp_r0 = c0.size();
    exp_r1 = c1.size();
  endtask

  function automatic bit pick_re(input int gap, input bit rnd);
    if (rnd) return ($urandom_range(0, gap) == 0);
    return ((tcyc % (gap + 1)) == gap);
  endfunction

  task automatic run_and_check(input string tag, input int gap, input bit rnd);
    int budget;
    budget = 20 * (gap + 1) * (exp_q.size() + 8);
    for (int i = 0; i < budget && got.size() < exp_q.size(); i++) step(pick_re(gap, rnd));
    spam_idle = 1'b0;
    step(1'b0);
    step(1'b0);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), int'(got[i]), int'(exp_q[i]));
    chk({tag, "_frames"}, int'(frames_sent), int'(exp_fs));
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_tx_empty"}, int'(tx_empty), 1);
    chk({tag, "_resid0"}, q0.size(), exp_r0);
    chk({tag, "_resid1"}, q1.size(), exp_r1);
  endtask

  typedef struct {
    int         n0;
    int         n1;
    bit         valid;
    logic [7:0] hdr;
    bit         gnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b1;
    tx_re = 1'b0;
    drive_src();

    vecs[0] = '{0,   0,  1'b0, 8'h00, 1'b0};
    vecs[1] = '{23,  0,  1'b0, 8'h00, 1'b0};
    vecs[2] = '{24,  0,  1'b1, 8'hA5, 1'b0};
    vecs[3] = '{0,   3,  1'b0, 8'h00, 1'b0};
    vecs[4] = '{0,   4,  1'b1, 8'h5A, 1'b1};
    vecs[5] = '{24,  4,  1'b1, 8'hA5, 1'b0};
    vecs[6] = '{23,  4,  1'b1, 8'h5A, 1'b1};
    vecs[7] = '{100, 50, 1'b1, 8'hA5, 1'b0};

    // Eligibility / first-grant table, each from a fresh reset with tx idle.
    foreach (vecs[v]) begin
      q0.delete(); q1.delete();
      do_reset();
      push0(vecs[v].n0);
      push1(vecs[v].n1);
      step(1'b0); step(1'b0); step(1'b0);
      chk($sformatf("vec%0d_tx_empty", v), int'(obs_empty), int'(!vecs[v].valid));
      chk($sformatf("vec%0d_tx_din", v), int'(obs_din), int'(vecs[v].hdr));
      if (vecs[v].valid) chk($sformatf("vec%0d_grant", v), int'(obs_grant), int'(vecs[v].gnt));
      chk($sformatf("vec%0d_no_pop", v), n_re0 + n_re1, 0);
    end

    // Single src0 frame 0x00..0x17, popped every cycle.
    q0.delete(); q1.delete();
    do_reset();
    seq = 8'd0;
    push0(24);
    n_re0 = 0; n_re1 = 0;
    build_expected();
    chk("t2_hdr_model", int'(exp_q[0]), 8'hA5);
    run_and_check("t2", 0, 1'b0);
    chk("t2_re0_pulses", n_re0, 24);
    chk("t2_re1_pulses", n_re1, 0);
    chk("t2_last_byte", int'(got[24]), 8'h17);

    // 23 bytes never start a frame; the 24th brings the header within 2 cycles.
    q0.delete(); q1.delete();
    do_reset();
    push0(23);
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      chk("t3_hold_empty", int'(obs_empty), 1);
    end
    chk("t3_no_pop", q0.size(), 23);
    push0(1);
    step(1'b0);
    step(1'b0);
    chk("t3_hdr_valid", int'(obs_empty), 0);
    chk("t3_hdr_byte", int'(obs_din), 8'hA5);
    build_expected();
    run_and_check("t3", 0, 1'b0);

    // Both sources continuously eligible: strict alternation A5/5A.
    q0.delete(); q1.delete();
    do_reset();
    push0(48);
    push1(8);
    build_expected();
    run_and_check("t4", 0, 1'b0);
    if (got.size() >= 56) begin
      chk("t4_hdr0", int'(got[0]), 8'hA5);
      chk("t4_hdr1", int'(got[25]), 8'h5A);
      chk("t4_hdr2", int'(got[30]), 8'hA5);
      chk("t4_hdr3", int'(got[55]), 8'h5A);
    end else chk("t4_stream_short", got.size(), 56);
    chk("t4_frames4", int'(frames_sent), 4);
    chk("t4_last_grant", int'(grant), 1);

    // Slow transmitter, tx_re toggling whenever nothing is offered.
    q0.delete(); q1.delete();
    do_reset();
    push0(24);
    push1(4);
    build_expected();
    spam_idle = 1'b1;
    run_and_check("t5", 10, 1'b0);

    // Source underflow mid-body stalls the stream without popping or counting.
    q0.delete(); q1.delete();
    do_reset();
    push0(24);
    build_expected();
    for (int i = 0; i < 100 && got.size() < 4; i++) step(1'b1);
    chk("t7_reached_body", got.size(), 4);
    force_e0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk("t7_stall_empty", int'(obs_empty), 1);
      chk("t7_stall_re", int'(obs_re0), 0);
    end
    force_e0 = 1'b0;
    run_and_check("t7", 0, 1'b0);

    // Reset after 5 body bytes: aborted frame lost, next frame starts clean.
    q0.delete(); q1.delete();
    do_reset();
    push0(48);
    got.delete();
    for (int i = 0; i < 100 && got.size() < 6; i++) step(1'b1);
    chk("t6_reached", got.size(), 6);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    chk("t6_abort_empty", int'(tx_empty), 1);
    chk("t6_abort_busy", int'(busy), 0);
    chk("t6_abort_q", q0.size(), 43);
    m_rr = 1'b0;
    exp_fs = 16'd0;
    build_expected();
    run_and_check("t6", 0, 1'b0);

    // Randomised traffic without reset between rounds, so rr and frames_sent carry over.
    q0.delete(); q1.delete();
    do_reset();
    for (int r = 0; r < 8; r++) begin
      int g;
      g = $urandom_range(0, 3);
      for (int i = $urandom_range(0, 80); i > 0; i--) q0.push_back(8'($urandom));
      for (int i = $urandom_range(0, 20); i > 0; i--) q1.push_back(8'($urandom));
      build_expected();
      run_and_check($sformatf("rnd%0d", r), g, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
